// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: job controller for the dot-product datapath.
// A start pulse latches a source base, destination base and pair count.
// For each pair the block reads mem1/mem2, issues the operands over a
// valid/ready handshake, waits for the result and writes it to mem3.
//
// Optional build macro: DOT_SEQ_TIMEOUT_EN adds a result-wait timeout and
// the sticky timeout_err output.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               job start pulse, synchronous job cancel
//   src_base, dst_base         first read / first write address
//   job_count                  number of pairs, 0..2^ADDR_WIDTH
//   busy, done                 job active, one-cycle completion pulse
//   mem_read_en/_address       read strobe and address shared by mem1/mem2
//   mem1_data_out/mem2_data_out read data, valid one cycle after the strobe
//   dp_valid/dp_vec_a/dp_vec_b operands to the dot-product unit
//   dp_ready                   dot-product unit accepts operands
//   dp_result_valid/dp_result  result from the dot-product unit
//   mem3_write_en/_address     result write strobe and address
//   mem3_data_in               result, zero-extended
//   timeout_err                sticky timeout flag (DOT_SEQ_TIMEOUT_EN only)
module dot_product_sequencer #(
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned VECTOR_ELEMENT_WIDTH = 8,
  parameter int unsigned RESULT_WIDTH         = 2 * VECTOR_ELEMENT_WIDTH,
  parameter int unsigned ADDR_WIDTH           = 5
`ifdef DOT_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES     = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_base,
  input  logic [ADDR_WIDTH-1:0]   dst_base,
  input  logic [ADDR_WIDTH:0]     job_count,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_read_en,
  output logic [ADDR_WIDTH-1:0]   mem_read_address,
  input  logic [DATA_WIDTH-1:0]   mem1_data_out,
  input  logic [DATA_WIDTH-1:0]   mem2_data_out,
  output logic                    dp_valid,
  output logic [DATA_WIDTH-1:0]   dp_vec_a,
  output logic [DATA_WIDTH-1:0]   dp_vec_b,
  input  logic                    dp_ready,
  input  logic                    dp_result_valid,
  input  logic [RESULT_WIDTH-1:0] dp_result,
  output logic                    mem3_write_en,
  output logic [ADDR_WIDTH-1:0]   mem3_write_address,
  output logic [DATA_WIDTH-1:0]   mem3_data_in
`ifdef DOT_SEQ_TIMEOUT_EN
  , output logic                  timeout_err
`endif
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] READ     = 3'd1;
  localparam logic [2:0] CAPTURE  = 3'd2;
  localparam logic [2:0] ISSUE    = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] WRITE    = 3'd5;
  localparam logic [2:0] FINISH   = 3'd6;

  logic [2:0]              state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   src_nxt, dst_nxt;
  logic [DATA_WIDTH-1:0]   vec_a_nxt, vec_b_nxt, wdata_nxt;
  logic                    busy_nxt, done_nxt, rd_en_nxt, dp_valid_nxt, wr_en_nxt;

`ifdef DOT_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            timeout_err_nxt;
`endif

  // Next-state and next-output logic; the address registers double as the
  // job's source/destination pointers.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    src_nxt   = mem_read_address;
    dst_nxt   = mem3_write_address;
    vec_a_nxt = dp_vec_a;
    vec_b_nxt = dp_vec_b;
    wdata_nxt = mem3_data_in;
`ifdef DOT_SEQ_TIMEOUT_EN
    to_cnt_nxt      = '0;
    timeout_err_nxt = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (start && !abort) begin
          src_nxt   = src_base;
          dst_nxt   = dst_base;
          cnt_nxt   = job_count;
          state_nxt = (job_count == '0) ? FINISH : READ;
`ifdef DOT_SEQ_TIMEOUT_EN
          timeout_err_nxt = 1'b0;
`endif
        end
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: begin
        vec_a_nxt = mem1_data_out;
        vec_b_nxt = mem2_data_out;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (dp_ready) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (dp_result_valid) begin
          wdata_nxt = DATA_WIDTH'(dp_result);
          state_nxt = WRITE;
        end
`ifdef DOT_SEQ_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
`endif
      end
      WRITE: begin
        src_nxt   = mem_read_address + ADDR_WIDTH'(1);
        dst_nxt   = mem3_write_address + ADDR_WIDTH'(1);
        cnt_nxt   = cnt - CNT_W'(1);
        state_nxt = (cnt == CNT_W'(1)) ? FINISH : READ;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every transition out of an active state.
    if (abort && (state != IDLE)) state_nxt = IDLE;

    // Strobes are high for the whole cycle spent in their state.
    busy_nxt     = (state_nxt != IDLE);
    done_nxt     = (state == FINISH) && !abort;
    rd_en_nxt    = (state_nxt == READ);
    dp_valid_nxt = (state_nxt == ISSUE);
    wr_en_nxt    = (state_nxt == WRITE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      mem_read_en        <= 1'b0;
      mem_read_address   <= '0;
      dp_valid           <= 1'b0;
      dp_vec_a           <= '0;
      dp_vec_b           <= '0;
      mem3_write_en      <= 1'b0;
      mem3_write_address <= '0;
      mem3_data_in       <= '0;
`ifdef DOT_SEQ_TIMEOUT_EN
      to_cnt             <= '0;
      timeout_err        <= 1'b0;
`endif
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      busy               <= busy_nxt;
      done               <= done_nxt;
      mem_read_en        <= rd_en_nxt;
      mem_read_address   <= src_nxt;
      dp_valid           <= dp_valid_nxt;
      dp_vec_a           <= vec_a_nxt;
      dp_vec_b           <= vec_b_nxt;
      mem3_write_en      <= wr_en_nxt;
      mem3_write_address <= dst_nxt;
      mem3_data_in       <= wdata_nxt;
`ifdef DOT_SEQ_TIMEOUT_EN
      to_cnt             <= to_cnt_nxt;
      timeout_err        <= timeout_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Testbench for dot_product_sequencer: memory and dot-product unit models,
// a read/write scoreboard with a separate monitor, and directed jobs.
`timescale 1ns/1ps
module tb_dot_product_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [AW-1:0] src_base, dst_base;
  logic [AW:0]   job_count;
  logic          busy, done, mem_read_en, dp_valid, dp_ready;
  logic [AW-1:0] mem_read_address, mem3_write_address;
  logic [DW-1:0] mem1_data_out, mem2_data_out, dp_vec_a, dp_vec_b, mem3_data_in;
  logic          dp_result_valid, mem3_write_en;
  logic [RW-1:0] dp_result;
`ifdef DOT_SEQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

`ifdef DOT_SEQ_TIMEOUT_EN
  dot_product_sequencer #(.TIMEOUT_CYCLES(8)) dut (
`else
  dot_product_sequencer dut (
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base),
    .dst_base(dst_base), .job_count(job_count), .abort(abort),
    .busy(busy), .done(done), .mem_read_en(mem_read_en),
    .mem_read_address(mem_read_address), .mem1_data_out(mem1_data_out),
    .mem2_data_out(mem2_data_out), .dp_valid(dp_valid), .dp_vec_a(dp_vec_a),
    .dp_vec_b(dp_vec_b), .dp_ready(dp_ready), .dp_result_valid(dp_result_valid),
    .dp_result(dp_result), .mem3_write_en(mem3_write_en),
    .mem3_write_address(mem3_write_address), .mem3_data_in(mem3_data_in)
`ifdef DOT_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // ---------------- models ----------------
  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] mem2 [32];

  always @(posedge clk) begin
    if (mem_read_en) begin
      mem1_data_out <= mem1[mem_read_address];
      mem2_data_out <= mem2[mem_read_address];
    end
  end

  int stall_len = 0;  // cycles dp_ready stays low after dp_valid rises
  int res_lat   = 1;  // result latency after handshake; 0 = never
  int stall_cnt, res_cnt, hs_cnt;

  assign dp_ready = (stall_cnt >= stall_len);

  function automatic logic [RW-1:0] dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [RW-1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + RW'(a[8*i +: 8]) * RW'(b[8*i +: 8]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 0; res_cnt <= 0; hs_cnt <= 0;
      dp_result_valid <= 1'b0; dp_result <= '0;
    end else begin
      if (!dp_valid) stall_cnt <= 0;
      else if (stall_cnt < stall_len) stall_cnt <= stall_cnt + 1;
      dp_result_valid <= 1'b0;
      if (res_cnt == 1) begin dp_result_valid <= 1'b1; res_cnt <= 0; end
      else if (res_cnt > 1) res_cnt <= res_cnt - 1;
      if (dp_valid && dp_ready) begin
        hs_cnt    <= hs_cnt + 1;
        dp_result <= dot(dp_vec_a, dp_vec_b);
        if (res_lat == 1) dp_result_valid <= 1'b1;
        else if (res_lat > 1) res_cnt <= res_lat - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [AW-1:0] exp_rd_q [$];
  logic [AW-1:0] exp_wa_q [$];
  logic [DW-1:0] exp_wd_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input int a);
    exp_rd_q.push_back(AW'(a));
  endtask

  task automatic push_wr(input int a, input int d);
    exp_wa_q.push_back(AW'(a));
    exp_wd_q.push_back(DW'(d));
  endtask

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_a, prev_b;

  // Monitor: pops expectations whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read_en) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(mem_read_address), 64'hdead);
        else check("rd_addr", 64'(mem_read_address), 64'(exp_rd_q.pop_front()));
      end
      if (mem3_write_en) begin
        wr_cnt++;
        if (exp_wa_q.size() == 0) check("wr_unexpected", 64'(mem3_write_address), 64'hdead);
        else begin
          check("wr_addr", 64'(mem3_write_address), 64'(exp_wa_q.pop_front()));
          check("wr_data", 64'(mem3_data_in), 64'(exp_wd_q.pop_front()));
        end
      end
      if (done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", 64'(dp_valid), 64'd1);
        check("hold_vec_a", 64'(dp_vec_a), 64'(prev_a));
        check("hold_vec_b", 64'(dp_vec_b), 64'(prev_b));
      end
      prev_stall = dp_valid && !dp_ready;
      prev_a     = dp_vec_a;
      prev_b     = dp_vec_b;
    end
  end

  // ---------------- stimulus ----------------
  task automatic fill_default();
    for (int k = 0; k < 32; k++) begin
      mem1[k] = {4{8'(k)}};
      mem2[k] = 32'h0101_0101;
    end
  endtask

  task automatic fill_basic();
    for (int k = 0; k < 4; k++) begin
      mem1[k] = {8'(4 + k), 8'(3 + k), 8'(2 + k), 8'(1 + k)};
      mem2[k] = mem1[k];
    end
  endtask

  task automatic issue_start(input int src, input int dst, input int cnt);
    @(negedge clk);
    src_base = AW'(src); dst_base = AW'(dst); job_count = (AW+1)'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts a job and returns the negedges from start acceptance to done.
  task automatic run_job(input string name, input int src, input int dst, input int cnt,
                         output int cycles);
    int n, d0;
    d0 = done_cnt;
    issue_start(src, dst, cnt);
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    @(negedge clk);
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    check({name, "_queues_empty"}, 64'(exp_rd_q.size() + exp_wa_q.size()), 64'd0);
    cycles = n;
  endtask

  initial begin
    int n, r0, w0, d0, h0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; job_count = '0;
    fill_default();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_strobes", 64'({mem_read_en, dp_valid, mem3_write_en}), 64'd0);
    check("rst_addrs", 64'({mem_read_address, mem3_write_address}), 64'd0);
    check("rst_vec_a", 64'(dp_vec_a), 64'd0);
    check("rst_vec_b", 64'(dp_vec_b), 64'd0);
    check("rst_wdata", 64'(mem3_data_in), 64'd0);

    // Basic job: results 30, 54, 86, 126 at 1..4, 5 cycles per pair
    fill_basic();
    for (int k = 0; k < 4; k++) push_rd(k);
    push_wr(1, 30); push_wr(2, 54); push_wr(3, 86); push_wr(4, 126);
    run_job("basic", 0, 1, 4, n);
    check("basic_latency", 64'(n), 64'd21);

    // Backpressure: 7 extra cycles per pair, operands held stable
    stall_len = 7;
    for (int k = 0; k < 4; k++) push_rd(k);
    push_wr(1, 30); push_wr(2, 54); push_wr(3, 86); push_wr(4, 126);
    run_job("bp", 0, 1, 4, n);
    check("bp_latency", 64'(n), 64'd49);
    stall_len = 0;

    // Wrap-around: reads 30,31,0 -> 120,124,0 written at 31,0,1
    fill_default();
    push_rd(30); push_rd(31); push_rd(0);
    push_wr(31, 120); push_wr(0, 124); push_wr(1, 0);
    run_job("wrap", 30, 31, 3, n);
    check("wrap_latency", 64'(n), 64'd16);

    // Zero count: done two edges after start, no strobes
    r0 = rd_cnt; w0 = wr_cnt;
    run_job("zero", 5, 5, 0, n);
    check("zero_latency", 64'(n), 64'd1);
    check("zero_no_strobes", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);

    // Full memory: 32 pairs, result 4*k at k
    w0 = wr_cnt;
    for (int k = 0; k < 32; k++) begin push_rd(k); push_wr(k, 4 * k); end
    run_job("full", 0, 0, 32, n);
    check("full_writes", 64'(wr_cnt - w0), 64'd32);

    // Start and abort together in IDLE: abort wins
    @(negedge clk);
    src_base = '0; dst_base = '0; job_count = 6'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_rd", 64'(mem_read_en), 64'd0);

    // Abort during WAIT_RES of pair 2 of 4
    res_lat = 4;
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt; h0 = hs_cnt;
    push_rd(4); push_rd(5); push_wr(10, 16);
    issue_start(4, 10, 4);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 200) begin @(negedge clk); n++; end
    check("abort_reached_pair2", 64'(hs_cnt - h0), 64'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_dp_valid", 64'(dp_valid), 64'd0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_writes", 64'(wr_cnt - w0), 64'd1);
    check("abort_reads", 64'(rd_cnt - r0), 64'd2);
    res_lat = 1;
    push_rd(0); push_rd(1); push_wr(2, 0); push_wr(3, 4);
    run_job("post_abort", 0, 2, 2, n);
    check("post_abort_latency", 64'(n), 64'd11);

`ifdef DOT_SEQ_TIMEOUT_EN
    // Timeout: no result ever; flag after 8 WAIT_RES cycles
    res_lat = 0;
    d0 = done_cnt; h0 = hs_cnt;
    push_rd(0);
    issue_start(0, 0, 2);
    n = 0;
    while (hs_cnt == h0 && n < 100) begin @(negedge clk); n++; end
    check("to_handshake", 64'(hs_cnt - h0), 64'd1);
    repeat (7) @(negedge clk);
    check("to_not_yet", 64'({timeout_err, busy}), 64'b01);
    @(negedge clk);
    check("to_flag", 64'(timeout_err), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("to_sticky", 64'(timeout_err), 64'd1);
    check("to_no_done", 64'(done_cnt - d0), 64'd0);
    res_lat = 1;
    push_rd(7); push_wr(20, 28);
    run_job("after_to", 7, 20, 1, n);
    check("to_cleared", 64'(timeout_err), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Job controller for the dot-product datapath. On a start command it reads COUNT vector pairs from mem1/mem2, issues each pair to the dot-product unit over a valid/ready handshake, and writes each result into mem3. It sits between the memory wrapper ports and the dot-product unit, and replaces the free-running start_processing/fsm_ready control with a bounded, addressable job interface.

Parameters:
DATA_WIDTH, 32, width of a packed vector word and of each mem3 word
VECTOR_ELEMENT_WIDTH, 8, width of one vector element
RESULT_WIDTH, 16, width of the dot-product result (2*VECTOR_ELEMENT_WIDTH)
ADDR_WIDTH, 5, memory address width
TIMEOUT_CYCLES, 64, result-wait limit; used only with the optional feature

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job start pulse
src_base  in  ADDR_WIDTH  first mem1/mem2 read address
dst_base  in  ADDR_WIDTH  first mem3 write address
job_count  in  ADDR_WIDTH+1  number of vector pairs, 0..2^ADDR_WIDTH
abort  in  1  synchronous job cancel
busy  out  1  high while a job is active
done  out  1  one-cycle pulse when the job completes
mem_read_en  out  1  read strobe shared by mem1 and mem2
mem_read_address  out  ADDR_WIDTH  read address shared by mem1 and mem2
mem1_data_out  in  DATA_WIDTH  mem1 read data, valid 1 cycle after the strobe
mem2_data_out  in  DATA_WIDTH  mem2 read data, valid 1 cycle after the strobe
dp_valid  out  1  operand pair valid
dp_vec_a  out  DATA_WIDTH  operand A
dp_vec_b  out  DATA_WIDTH  operand B
dp_ready  in  1  dot-product unit accepts operands
dp_result_valid  in  1  result strobe
dp_result  in  RESULT_WIDTH  result value
mem3_write_en  out  1  result write strobe
mem3_write_address  out  ADDR_WIDTH  result write address
mem3_data_in  out  DATA_WIDTH  result, zero-extended to DATA_WIDTH
timeout_err  out  1  sticky error flag; exists only with the optional feature

Behaviour:
- Reset: state IDLE; busy, done, mem_read_en, dp_valid and mem3_write_en are 0; addresses, operands, mem3_data_in and the internal count are 0.
- Every output is registered.
- States and transitions:
  - IDLE: on start, latch src_base, dst_base and job_count, set busy=1 and go to READ. If the latched job_count is 0, go to FINISH instead.
  - READ: assert mem_read_en for 1 cycle at the current source address, then go to CAPTURE.
  - CAPTURE: register mem1_data_out into dp_vec_a and mem2_data_out into dp_vec_b, set dp_valid=1, go to ISSUE.
  - ISSUE: hold dp_valid and both operands stable until the cycle where dp_valid&&dp_ready. On that cycle drop dp_valid and go to WAIT_RES.
  - WAIT_RES: on dp_result_valid, register the result and go to WRITE. A dp_result_valid seen in any other state is ignored.
  - WRITE: pulse mem3_write_en for 1 cycle with mem3_write_address=current destination address and mem3_data_in={zeros,dp_result}. Increment both addresses and decrement the count. If count is now 0 go to FINISH, else go to READ.
  - FINISH: pulse done for 1 cycle, clear busy, go to IDLE.
- Addresses wrap modulo 2^ADDR_WIDTH (31+1 -> 0).
- Job length: job_count=2^ADDR_WIDTH processes the full memory.
- Pair latency with dp_ready held high and a 1-cycle result: 5 cycles from READ to WRITE.
- start is ignored while busy=1.
- abort: from any non-IDLE state, the next state is IDLE with busy=0 and dp_valid=0, no done pulse, and no further memory strobes. A write already issued in the same cycle completes.
- start and abort in the same cycle while in IDLE: abort wins and the job does not start.
- Asynchronous reset mid-job returns all outputs to their reset values immediately.

Optional Feature:
DOT_SEQ_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_RES. If dp_result_valid has not arrived after TIMEOUT_CYCLES cycles, set timeout_err=1 and take the abort path (IDLE, no done pulse).
  - timeout_err stays high until the next accepted start or reset.
- Undefined: no timeout_err port, no counter; WAIT_RES waits indefinitely.

Test Plan:
- Basic job: mem1[k]=mem2[k]={1+k,2+k,3+k,4+k} for k=0..3; src_base=0, dst_base=1, job_count=4; dp_ready=1 -> mem3[1..4]=30,54,86,126; exactly one done pulse; busy low afterwards.
- Backpressure: dp_ready held low 7 cycles per pair -> dp_vec_a and dp_vec_b stable while dp_valid=1; same results as the basic job; no duplicate mem3 writes.
- Wrap-around: src_base=30, dst_base=31, job_count=3 -> reads at 30,31,0 and writes at 31,0,1.
- Zero and full counts: job_count=0 -> done 2 cycles after start and no memory strobes; job_count=32 -> 32 writes and done.
- Abort: assert abort while in WAIT_RES of pair 2 of 4 -> busy=0 the next cycle, no done, only 1 mem3 write; a subsequent start runs normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): dp_result_valid never asserted -> timeout_err=1 after 8 WAIT_RES cycles and busy=0; timeout_err clears on the next start.
